// File: rtl/sync_pkt_fifo_if.sv
// Valid/ready bundle for sync_pkt_fifo: write side, read side and status flags.
// The FIFO is the slave; the producer/consumer environment holds the master view.
interface sync_pkt_fifo_if #(
   parameter int SIZE     = 16,
   parameter int DAT_BITS = 8
);
   localparam int ABITS = $clog2(SIZE);

   logic                i_flush;
   logic                i_val;
   logic [DAT_BITS-1:0] i_dat;
   logic                i_eop;
   logic                i_err;
   logic                o_rdy;
   logic                o_full;
   logic                o_afull;
   logic                o_val;
   logic [DAT_BITS-1:0] o_dat;
   logic                o_eop;
   logic                i_rdy;
   logic                o_emp;
   logic                o_aemp;
   logic [ABITS:0]      o_wrds;
   logic                o_drop;

   modport slave (
      input  i_flush, i_val, i_dat, i_eop, i_err, i_rdy,
      output o_rdy, o_full, o_afull, o_val, o_dat, o_eop, o_emp, o_aemp, o_wrds, o_drop
   );

   modport master (
      output i_flush, i_val, i_dat, i_eop, i_err, i_rdy,
      input  o_rdy, o_full, o_afull, o_val, o_dat, o_eop, o_emp, o_aemp, o_wrds, o_drop
   );
endinterface

// File: rtl/sync_pkt_fifo.sv
// Single-clock FIFO with flags, flush and optional store-and-forward packet mode.
// Packet mode exposes only committed packets; errored or oversize packets are discarded.
module sync_pkt_fifo #(
   parameter int SIZE     = 16,
   parameter int DAT_BITS = 8,
   parameter bit PKT_MODE = 1'b0,
   parameter int AFULL    = SIZE - 2,
   parameter int AEMP     = 1
) (
   input  logic           i_clk,
   input  logic           i_rst,
   sync_pkt_fifo_if.slave bus
);
   localparam int ABITS = $clog2(SIZE);
   localparam int PW    = ABITS + 1;
   localparam logic [PW-1:0] SIZE_P  = PW'(SIZE);
   localparam logic [PW-1:0] AFULL_P = PW'(AFULL);
   localparam logic [PW-1:0] AEMP_P  = PW'(AEMP);

   logic [DAT_BITS:0] mem [SIZE];
   logic [PW-1:0]     wr_ptr, wr_cmt, rd_ptr;
   logic [PW-1:0]     wr_ptr_n, wr_cmt_n, rd_ptr_n;
   logic [PW-1:0]     used, rdbl;
   logic              drop, drop_n, drop_pls, drop_pls_n;
   logic              full, wr_acc, rd_acc, ovf, bad_eop, store;

   assign used = wr_ptr - rd_ptr;
   assign rdbl = wr_cmt - rd_ptr;
   assign full = (used == SIZE_P);

   assign bus.o_rdy   = ~i_rst && (drop || !full);
   assign bus.o_full  = full;
   assign bus.o_afull = (used >= AFULL_P);
   assign bus.o_val   = (rdbl != '0);
   assign bus.o_emp   = (rdbl == '0);
   assign bus.o_aemp  = (rdbl <= AEMP_P);
   assign bus.o_wrds  = rdbl;
   assign bus.o_drop  = drop_pls;
   assign {bus.o_eop, bus.o_dat} = mem[rd_ptr[ABITS-1:0]];

   assign wr_acc = bus.i_val && bus.o_rdy;
   assign rd_acc = bus.o_val && bus.i_rdy;
   // Whole array filled by one uncommitted packet: it can never complete, so discard it.
   assign ovf     = PKT_MODE && full && (wr_cmt == rd_ptr) && !drop;
   assign bad_eop = PKT_MODE && wr_acc && bus.i_eop && bus.i_err && !drop;
   assign store   = wr_acc && !drop && !bad_eop && !bus.i_flush;

   always_comb begin
      wr_ptr_n   = wr_ptr;
      wr_cmt_n   = wr_cmt;
      rd_ptr_n   = rd_ptr;
      drop_n     = drop;
      drop_pls_n = 1'b0;
      if (rd_acc)
         rd_ptr_n = rd_ptr + 1'b1;
      if (ovf) begin
         drop_n   = 1'b1;
         wr_ptr_n = wr_cmt;
      end else if (drop) begin
         // Beats are swallowed until the packet's eop arrives.
         if (wr_acc && bus.i_eop) begin
            drop_n     = 1'b0;
            drop_pls_n = 1'b1;
         end
      end else if (bad_eop) begin
         wr_ptr_n   = wr_cmt;
         drop_pls_n = 1'b1;
      end else if (wr_acc) begin
         wr_ptr_n = wr_ptr + 1'b1;
         if (!PKT_MODE || bus.i_eop)
            wr_cmt_n = wr_ptr + 1'b1;
      end
      if (bus.i_flush) begin
         wr_ptr_n   = '0;
         wr_cmt_n   = '0;
         rd_ptr_n   = '0;
         drop_n     = 1'b0;
         drop_pls_n = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         wr_cmt   <= '0;
         rd_ptr   <= '0;
         drop     <= 1'b0;
         drop_pls <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_n;
         wr_cmt   <= wr_cmt_n;
         rd_ptr   <= rd_ptr_n;
         drop     <= drop_n;
         drop_pls <= drop_pls_n;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < SIZE; i++)
            mem[i] <= '0;
      end else if (store) begin
         mem[wr_ptr[ABITS-1:0]] <= {bus.i_eop, bus.i_dat};
      end
   end
endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Self-checking bench: plain-mode and packet-mode instances (SIZE=4) against
// directed expectations and a queue-based occupancy model for random streaming.
module tb_sync_pkt_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   sync_pkt_fifo_if #(.SIZE(4), .DAT_BITS(8)) bp ();
   sync_pkt_fifo_if #(.SIZE(4), .DAT_BITS(8)) bk ();

   sync_pkt_fifo #(.SIZE(4), .DAT_BITS(8), .PKT_MODE(1'b0), .AFULL(2), .AEMP(1)) u_plain (
      .i_clk(clk), .i_rst(rst), .bus(bp));
   sync_pkt_fifo #(.SIZE(4), .DAT_BITS(8), .PKT_MODE(1'b1), .AFULL(2), .AEMP(1)) u_pkt (
      .i_clk(clk), .i_rst(rst), .bus(bk));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_k(input logic [7:0] d, input logic e, input logic r);
      bk.i_val = 1'b1; bk.i_dat = d; bk.i_eop = e; bk.i_err = r;
      chk("k_rdy", bk.o_rdy, 1);
      tick();
      bk.i_val = 1'b0; bk.i_eop = 1'b0; bk.i_err = 1'b0;
   endtask

   int   q[$];
   int   nxt_wr, nxt_rd;
   logic m_rdy, pop, push;

   initial begin
      {bp.i_flush, bp.i_val, bp.i_dat, bp.i_eop, bp.i_err, bp.i_rdy} = '0;
      {bk.i_flush, bk.i_val, bk.i_dat, bk.i_eop, bk.i_err, bk.i_rdy} = '0;

      // reset values
      tick();
      chk("rst_rdy", bp.o_rdy, 0);
      chk("rst_val", bp.o_val, 0);
      chk("rst_dat", bp.o_dat, 0);
      chk("rst_eop", bp.o_eop, 0);
      chk("rst_emp", bp.o_emp, 1);
      chk("rst_aemp", bp.o_aemp, 1);
      chk("rst_wrds", bp.o_wrds, 0);
      chk("rst_full", bp.o_full, 0);
      chk("rst_afull", bp.o_afull, 0);
      chk("rst_drop", bk.o_drop, 0);
      rst = 1'b0;
      #1;
      chk("rel_rdy", bp.o_rdy, 1);
      chk("rel_rdy_k", bk.o_rdy, 1);

      // plain fill to full, then drain in order
      for (int i = 0; i < 4; i++) begin
         bp.i_val = 1'b1; bp.i_dat = 8'(8'hA0 + i);
         chk("fill_wrds", bp.o_wrds, i);
         chk("fill_val", bp.o_val, (i != 0));
         chk("fill_rdy", bp.o_rdy, 1);
         tick();
      end
      bp.i_val = 1'b0;
      chk("full_full", bp.o_full, 1);
      chk("full_rdy", bp.o_rdy, 0);
      chk("full_wrds", bp.o_wrds, 4);
      chk("full_afull", bp.o_afull, 1);
      chk("full_aemp", bp.o_aemp, 0);
      bp.i_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_val", bp.o_val, 1);
         chk("drain_dat", bp.o_dat, 8'hA0 + i);
         tick();
      end
      bp.i_rdy = 1'b0;
      chk("drain_emp", bp.o_emp, 1);
      chk("drain_val0", bp.o_val, 0);

      // random concurrent stream against an occupancy model
      nxt_wr = 0; nxt_rd = 0;
      for (int cyc = 0; cyc < 3000 && nxt_rd < 100; cyc++) begin
         bp.i_val = ($urandom_range(0, 1) == 1) && (nxt_wr < 100);
         bp.i_dat = 8'(nxt_wr);
         bp.i_rdy = ($urandom_range(0, 1) == 1);
         m_rdy = (q.size() != 4);
         chk("rnd_rdy", bp.o_rdy, m_rdy);
         chk("rnd_val", bp.o_val, (q.size() != 0));
         chk("rnd_wrds", bp.o_wrds, q.size());
         chk("rnd_afull", bp.o_afull, (q.size() >= 2));
         chk("rnd_aemp", bp.o_aemp, (q.size() <= 1));
         pop  = bp.i_rdy && (q.size() != 0);
         push = bp.i_val && m_rdy;
         if (pop) begin
            chk("rnd_dat", bp.o_dat, 8'(nxt_rd));
            void'(q.pop_front());
            nxt_rd++;
         end
         if (push) begin
            q.push_back(nxt_wr);
            nxt_wr++;
         end
         tick();
      end
      chk("rnd_count", nxt_rd, 100);
      bp.i_val = 1'b0; bp.i_rdy = 1'b1;
      repeat (5) tick();
      bp.i_rdy = 1'b0;

      // flush with 3 stored, colliding with a write and a read
      for (int i = 0; i < 3; i++) begin
         bp.i_val = 1'b1; bp.i_dat = 8'(8'h70 + i);
         tick();
      end
      bp.i_val = 1'b0;
      chk("pre_flush_wrds", bp.o_wrds, 3);
      bp.i_flush = 1'b1; bp.i_val = 1'b1; bp.i_dat = 8'h55; bp.i_rdy = 1'b1;
      tick();
      bp.i_flush = 1'b0; bp.i_val = 1'b0; bp.i_rdy = 1'b0;
      chk("flush_emp", bp.o_emp, 1);
      chk("flush_wrds", bp.o_wrds, 0);
      chk("flush_val", bp.o_val, 0);
      chk("flush_full", bp.o_full, 0);
      bp.i_val = 1'b1; bp.i_dat = 8'h66;
      tick();
      bp.i_val = 1'b0;
      chk("post_flush_wrds", bp.o_wrds, 1);
      chk("post_flush_dat", bp.o_dat, 8'h66);
      bp.i_rdy = 1'b1;
      tick();
      bp.i_rdy = 1'b0;
      chk("post_flush_emp", bp.o_emp, 1);

      // packet mode: good 3-beat packet, then errored 2-beat packet
      send_k(8'h10, 1'b0, 1'b0);
      chk("pk_hold1", bk.o_val, 0);
      send_k(8'h11, 1'b0, 1'b0);
      chk("pk_hold2", bk.o_val, 0);
      send_k(8'h12, 1'b1, 1'b0);
      chk("pk_commit_val", bk.o_val, 1);
      chk("pk_commit_wrds", bk.o_wrds, 3);
      bk.i_rdy = 1'b1;
      chk("pk_dat0", bk.o_dat, 8'h10);
      send_k(8'h20, 1'b0, 1'b0);
      chk("pk_dat1", bk.o_dat, 8'h11);
      chk("pk_nodrop", bk.o_drop, 0);
      send_k(8'h21, 1'b1, 1'b1);
      chk("pk_err_drop", bk.o_drop, 1);
      chk("pk_dat2", bk.o_dat, 8'h12);
      chk("pk_eop2", bk.o_eop, 1);
      chk("pk_wrds_after_err", bk.o_wrds, 1);
      tick();
      chk("pk_drop_once", bk.o_drop, 0);
      chk("pk_emp", bk.o_emp, 1);
      bk.i_rdy = 1'b0;

      // packet mode: oversize 6-beat packet discarded, next packet intact
      for (int i = 0; i < 4; i++) send_k(8'(8'h30 + i), 1'b0, 1'b0);
      chk("ovf_full", bk.o_full, 1);
      chk("ovf_rdy0", bk.o_rdy, 0);
      chk("ovf_val", bk.o_val, 0);
      tick();
      chk("ovf_drop_rdy", bk.o_rdy, 1);
      chk("ovf_drop_full", bk.o_full, 0);
      chk("ovf_drop_wrds", bk.o_wrds, 0);
      send_k(8'h34, 1'b0, 1'b0);
      chk("ovf_no_pulse", bk.o_drop, 0);
      send_k(8'h35, 1'b1, 1'b0);
      chk("ovf_pulse", bk.o_drop, 1);
      chk("ovf_emp", bk.o_emp, 1);
      chk("ovf_wrds", bk.o_wrds, 0);
      tick();
      chk("ovf_pulse_end", bk.o_drop, 0);
      send_k(8'h40, 1'b0, 1'b0);
      send_k(8'h41, 1'b1, 1'b0);
      chk("nxt_wrds", bk.o_wrds, 2);
      bk.i_rdy = 1'b1;
      chk("nxt_dat0", bk.o_dat, 8'h40);
      chk("nxt_eop0", bk.o_eop, 0);
      tick();
      chk("nxt_dat1", bk.o_dat, 8'h41);
      chk("nxt_eop1", bk.o_eop, 1);
      tick();
      bk.i_rdy = 1'b0;
      chk("nxt_emp", bk.o_emp, 1);

      // asynchronous reset mid-stream
      bp.i_val = 1'b1; bp.i_dat = 8'h80;
      tick();
      bp.i_dat = 8'h81;
      tick();
      bp.i_val = 1'b0;
      chk("ar_pre_wrds", bp.o_wrds, 2);
      #2 rst = 1'b1;
      #1;
      chk("ar_val", bp.o_val, 0);
      chk("ar_emp", bp.o_emp, 1);
      chk("ar_wrds", bp.o_wrds, 0);
      chk("ar_dat", bp.o_dat, 0);
      chk("ar_rdy", bp.o_rdy, 0);
      chk("ar_rdy_k", bk.o_rdy, 0);
      tick();
      chk("ar_hold_rdy", bp.o_rdy, 0);
      rst = 1'b0;
      #1;
      chk("ar_rel_rdy", bp.o_rdy, 1);
      chk("ar_rel_emp", bp.o_emp, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
